// File: rtl/wbimgburst.sv
// Frame-buffer reader: pipelined Wishbone line fetches into a FIFO, streamed out as tagged pixels.
// Latency: first stb two cycles after i_newframe; a word acked at cycle M shows on o_valid at M+1.
// Backpressure: i_ready low lets the FIFO fill; a burst starts only when its words fit in free space.
// Ports: i_clk/i_reset_n; frame config (i_newframe, i_baseaddr, i_stride, i_linewords, i_nlines);
//   Wishbone master (o_wb_cyc/stb/addr, i_wb_stall/ack/err/data); stream (o_valid, i_ready,
//   o_data, o_sof, o_last); status (o_busy, o_err).

// Show-ahead FIFO with synchronous flush; the head entry is always on pop_dat.
// Latency: a push is visible on pop_vld/pop_dat the cycle after it is written.
// Backpressure: none internally; the writer must never push into a full FIFO.
// Ports: clk/rst_n, flush, push_vld/push_dat, pop_rdy/pop_vld/pop_dat, fill (entry count).
module wbimgburst_fifo #(
  parameter int W  = 34,
  parameter int LG = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push_vld,
  input  logic [W-1:0] push_dat,
  input  logic         pop_rdy,
  output logic         pop_vld,
  output logic [W-1:0] pop_dat,
  output logic [LG:0]  fill
);
  logic [W-1:0]  mem [0:(2**LG)-1];
  logic [LG-1:0] wr_ptr;
  logic [LG-1:0] rd_ptr;
  logic          pop;

  assign pop_vld = (fill != '0);
  assign pop     = pop_vld && pop_rdy;
  assign pop_dat = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_vld) mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
    end else begin
      if (push_vld) wr_ptr <= wr_ptr + LG'(1);
      if (pop)      rd_ptr <= rd_ptr + LG'(1);
      case ({push_vld, pop})
        2'b10:   fill <= fill + (LG+1)'(1);
        2'b01:   fill <= fill - (LG+1)'(1);
        default: ;
      endcase
    end
  end
endmodule

module wbimgburst #(
  parameter int AW      = 24,
  parameter int DW      = 32,
  parameter int LGFIFO  = 10,
  parameter int LW      = 11,
  parameter int LGBURST = 4
) (
  input  logic            i_clk,
  input  logic            i_reset_n,
  input  logic            i_newframe,
  input  logic [AW-1:0]   i_baseaddr,
  input  logic [AW-1:0]   i_stride,
  input  logic [LGFIFO:0] i_linewords,
  input  logic [LW-1:0]   i_nlines,
  output logic            o_wb_cyc,
  output logic            o_wb_stb,
  output logic [AW-1:0]   o_wb_addr,
  input  logic            i_wb_stall,
  input  logic            i_wb_ack,
  input  logic            i_wb_err,
  input  logic [DW-1:0]   i_wb_data,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [DW-1:0]   o_data,
  output logic            o_sof,
  output logic            o_last,
  output logic            o_busy,
  output logic            o_err
);
  localparam int BW = LGBURST + 1;
  localparam int CW = LGFIFO + 1;
  localparam int FW = LGFIFO + 2;
  localparam logic [BW-1:0] MAXB  = BW'(2**LGBURST);
  localparam logic [FW-1:0] DEPTH = FW'(2**LGFIFO);

  typedef enum logic [2:0] {IDLE, ROOM, BURST, DRAIN, ERROR} state_t;

  state_t        state;
  logic          cyc, stb, busy, err;
  logic [AW-1:0] addr, linebase, stride;
  logic [CW-1:0] linewords, req_word, ack_word, words_left;
  logic [LW-1:0] nlines, req_line, ack_line;
  logic [BW-1:0] blen, blen_left, outstanding, out_next;
  logic [CW-1:0] fill;
  logic [FW-1:0] free;
  logic          accept, ack_in, push, flush, fifo_vld;
  logic [DW+1:0] push_dat, pop_dat;

  // Bursts stop at the line end so a line never straddles two bursts.
  assign words_left = linewords - req_word;
  assign blen       = (words_left < CW'(MAXB)) ? BW'(words_left) : MAXB;
  assign free       = DEPTH - FW'(fill) - FW'(outstanding);

  assign accept   = stb && !i_wb_stall;
  assign ack_in   = i_wb_ack && cyc;
  assign out_next = outstanding + BW'(accept) - BW'(ack_in);
  assign push     = ack_in && (state != ERROR);
  assign flush    = i_newframe || i_wb_err;
  assign push_dat = {(ack_line == '0) && (ack_word == '0),
                     (ack_word == linewords - CW'(1)),
                     i_wb_data};

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state       <= IDLE;
      cyc         <= 1'b0;
      stb         <= 1'b0;
      busy        <= 1'b0;
      err         <= 1'b0;
      addr        <= '0;
      linebase    <= '0;
      stride      <= '0;
      linewords   <= '0;
      nlines      <= '0;
      req_word    <= '0;
      req_line    <= '0;
      ack_word    <= '0;
      ack_line    <= '0;
      blen_left   <= '0;
      outstanding <= '0;
    end else if (i_newframe) begin
      // Restart wins over a simultaneous bus error.
      state       <= ROOM;
      cyc         <= 1'b0;
      stb         <= 1'b0;
      busy        <= 1'b1;
      err         <= 1'b0;
      addr        <= i_baseaddr;
      linebase    <= i_baseaddr;
      stride      <= i_stride;
      linewords   <= i_linewords;
      nlines      <= i_nlines;
      req_word    <= '0;
      req_line    <= '0;
      ack_word    <= '0;
      ack_line    <= '0;
      blen_left   <= '0;
      outstanding <= '0;
    end else if (i_wb_err) begin
      state       <= ERROR;
      cyc         <= 1'b0;
      stb         <= 1'b0;
      busy        <= 1'b0;
      err         <= 1'b1;
      outstanding <= '0;
    end else begin
      outstanding <= out_next;
      if (push) begin
        if (ack_word == linewords - CW'(1)) begin
          ack_word <= '0;
          ack_line <= ack_line + LW'(1);
        end else begin
          ack_word <= ack_word + CW'(1);
        end
      end
      case (state)
        ROOM: begin
          if (linewords == '0 || nlines == '0) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (free >= FW'(blen)) begin
            cyc       <= 1'b1;
            stb       <= 1'b1;
            blen_left <= blen;
            state     <= BURST;
          end
        end
        BURST: begin
          if (accept) begin
            if (req_word == linewords - CW'(1)) begin
              req_word <= '0;
              req_line <= req_line + LW'(1);
              addr     <= linebase + stride;
              linebase <= linebase + stride;
            end else begin
              req_word <= req_word + CW'(1);
              addr     <= addr + AW'(1);
            end
            blen_left <= blen_left - BW'(1);
            if (blen_left == BW'(1)) begin
              stb   <= 1'b0;
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (out_next == '0) begin
            cyc <= 1'b0;
            if (req_line == nlines) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              state <= ROOM;
            end
          end
        end
        default: ;
      endcase
    end
  end

  wbimgburst_fifo #(
    .W  (DW + 2),
    .LG (LGFIFO)
  ) u_fifo (
    .clk      (i_clk),
    .rst_n    (i_reset_n),
    .flush    (flush),
    .push_vld (push),
    .push_dat (push_dat),
    .pop_rdy  (i_ready),
    .pop_vld  (fifo_vld),
    .pop_dat  (pop_dat),
    .fill     (fill)
  );

  // A restart pulse drops the bus cycle combinationally in the cycle it is seen.
  assign o_wb_cyc  = cyc && !i_newframe;
  assign o_wb_stb  = stb && !i_newframe;
  assign o_wb_addr = addr;
  assign o_valid   = fifo_vld;
  assign o_data    = pop_dat[DW-1:0];
  assign o_sof     = fifo_vld && pop_dat[DW+1];
  assign o_last    = fifo_vld && pop_dat[DW];
  assign o_busy    = busy;
  assign o_err     = err;
endmodule

// File: tb/tb_wbimgburst.sv
// Directed bench for wbimgburst: Wishbone slave model with stall/ack jitter and a stream sink.
// Latency: one call to tick() advances one clock; inputs change and outputs are read mid-cycle.
// Backpressure: the sink's ready is held low, high or randomised per test.
module tb_wbimgburst;
  logic        clk = 1'b0;
  logic        reset_n, newframe;
  logic [23:0] baseaddr, stride;
  logic [10:0] linewords, nlines;
  logic        wb_cyc, wb_stb, wb_stall, wb_ack, wb_err;
  logic [23:0] wb_addr;
  logic [31:0] wb_data, data;
  logic        valid, ready, sof, last, busy, err;

  always #5 clk = ~clk;

  wbimgburst dut (
    .i_clk(clk), .i_reset_n(reset_n), .i_newframe(newframe),
    .i_baseaddr(baseaddr), .i_stride(stride), .i_linewords(linewords), .i_nlines(nlines),
    .o_wb_cyc(wb_cyc), .o_wb_stb(wb_stb), .o_wb_addr(wb_addr),
    .i_wb_stall(wb_stall), .i_wb_ack(wb_ack), .i_wb_err(wb_err), .i_wb_data(wb_data),
    .o_valid(valid), .i_ready(ready), .o_data(data), .o_sof(sof), .o_last(last),
    .o_busy(busy), .o_err(err)
  );

  typedef struct { logic [23:0] a; int due; } req_t;

  int n_chk = 0, n_err = 0;
  int cyc_n = 0;
  int stall_pct = 0, ack_dmax = 0, rdy_mode = 1, err_after = 0;
  req_t        pend[$];
  logic [23:0] acc_q[$];
  logic [33:0] rx_q[$];
  int          blen_q[$];
  int  nbursts, cur_blen, n_acc, n_pop, max_infl, stb_cnt, busy_cnt, ack_total;
  int  first_ack_cyc, first_vld_cyc, last_ack_cyc, busy_fall_cyc, err_cyc, stall_bad;
  bit  prev_cyc = 1'b0, prev_busy = 1'b0, stall_hold = 1'b0, err_seen;
  logic [23:0] stall_addr = '0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clear_stats();
    pend.delete(); acc_q.delete(); rx_q.delete(); blen_q.delete();
    nbursts = 0; cur_blen = 0; n_acc = 0; n_pop = 0; max_infl = 0; stb_cnt = 0;
    busy_cnt = 0; ack_total = 0; first_ack_cyc = -1; first_vld_cyc = -1;
    last_ack_cyc = -1; busy_fall_cyc = -1; err_cyc = -1; stall_bad = 0; err_seen = 0;
  endtask

  // One clock: slave response, request capture, sink; called just after a falling edge.
  task automatic tick();
    req_t r;
    #1;
    if (stall_hold && reset_n && !newframe && !wb_err && !(wb_stb && wb_addr == stall_addr))
      stall_bad++;
    wb_stall = (stall_pct > 0) && ($urandom_range(99) < stall_pct);
    if (wb_cyc && !prev_cyc) begin nbursts++; cur_blen = 0; end
    if (!wb_cyc && prev_cyc) blen_q.push_back(cur_blen);
    prev_cyc = wb_cyc;
    if (prev_busy && !busy) busy_fall_cyc = cyc_n;
    prev_busy = busy;
    if (busy) busy_cnt++;
    if (wb_stb) stb_cnt++;
    stall_hold = wb_stb && wb_stall;
    stall_addr = wb_addr;
    wb_ack = 1'b0; wb_err = 1'b0; wb_data = '0;
    if (!wb_cyc) pend.delete();
    else if (pend.size() > 0 && pend[0].due <= cyc_n) begin
      r = pend.pop_front();
      ack_total++;
      if (err_after != 0 && ack_total == err_after) begin
        wb_err = 1'b1; err_seen = 1'b1; err_cyc = cyc_n;
      end else begin
        wb_ack = 1'b1; wb_data = {8'hC3, r.a};
        if (first_ack_cyc < 0) first_ack_cyc = cyc_n;
        last_ack_cyc = cyc_n;
      end
    end
    if (wb_cyc && wb_stb && !wb_stall) begin
      r.a = wb_addr;
      r.due = cyc_n + 1 + int'($urandom_range(ack_dmax));
      pend.push_back(r); acc_q.push_back(wb_addr); n_acc++; cur_blen++;
    end
    case (rdy_mode)
      0:       ready = 1'b0;
      1:       ready = 1'b1;
      default: ready = ($urandom_range(1) == 1);
    endcase
    if (valid && first_vld_cyc < 0) first_vld_cyc = cyc_n;
    if (valid && ready) begin rx_q.push_back({sof, last, data}); n_pop++; end
    if (n_acc - n_pop > max_infl) max_infl = n_acc - n_pop;
    @(negedge clk);
    cyc_n++;
  endtask

  task automatic pulse(input logic [23:0] b, input logic [23:0] s,
                       input logic [10:0] lw, input logic [10:0] nl);
    baseaddr = b; stride = s; linewords = lw; nlines = nl; newframe = 1'b1;
    tick();
    newframe = 1'b0;
    // Scramble the config so any use of the live inputs shows up.
    baseaddr = 24'hABCDEF; stride = 24'h000005; linewords = 11'd3; nlines = 11'd1;
  endtask

  task automatic wait_done(input string tag, input int nwords);
    int n = 0;
    while ((busy || rx_q.size() < nwords) && n < 20000) begin tick(); n++; end
    chk({tag, " finished"}, 64'(n < 20000), 64'd1);
  endtask

  function automatic logic [33:0] exp_word(input logic [23:0] b, input logic [23:0] s,
                                           input int lw, input int i);
    int ln, w;
    logic [23:0] a;
    ln = i / lw;
    w  = i % lw;
    a  = b + 24'(ln) * s + 24'(w);
    return {(i == 0), (w == lw - 1), 8'hC3, a};
  endfunction

  task automatic check_frame(input string tag, input logic [23:0] b, input logic [23:0] s,
                             input int lw, input int nl);
    int bad_d = 0, bad_a = 0;
    logic [33:0] e;
    for (int i = 0; i < lw * nl; i++) begin
      e = exp_word(b, s, lw, i);
      if (i >= rx_q.size() || rx_q[i] !== e) bad_d++;
      if (i >= acc_q.size() || acc_q[i] !== e[23:0]) bad_a++;
    end
    chk({tag, " words"}, 64'(rx_q.size()), 64'(lw * nl));
    chk({tag, " reqs"},  64'(acc_q.size()), 64'(lw * nl));
    chk({tag, " data"},  64'(bad_d), 64'd0);
    chk({tag, " addrs"}, 64'(bad_a), 64'd0);
  endtask

  initial begin
    int n;
    reset_n = 1'b0; newframe = 1'b0; baseaddr = '0; stride = '0; linewords = '0; nlines = '0;
    wb_stall = 1'b0; wb_ack = 1'b0; wb_err = 1'b0; wb_data = '0; ready = 1'b0;
    clear_stats();
    @(negedge clk);

    // Reset values
    tick(); tick();
    chk("rst cyc", 64'(wb_cyc), 64'd0);
    chk("rst stb", 64'(wb_stb), 64'd0);
    chk("rst addr", 64'(wb_addr), 64'd0);
    chk("rst valid/sof/last", 64'({valid, sof, last}), 64'd0);
    chk("rst busy/err", 64'({busy, err}), 64'd0);
    reset_n = 1'b1;
    tick();

    // Single burst per line: 2 lines of 8, stride 16, base 0x100
    clear_stats(); rdy_mode = 1;
    pulse(24'h000100, 24'h000010, 11'd8, 11'd2);
    chk("t1 busy at N+1", 64'(busy), 64'd1);
    chk("t1 no stb at N+1", 64'(wb_stb), 64'd0);
    tick();
    chk("t1 stb at N+2", 64'(wb_stb), 64'd1);
    chk("t1 first addr", 64'(wb_addr), 64'h100);
    wait_done("t1", 16);
    check_frame("t1", 24'h000100, 24'h000010, 8, 2);
    chk("t1 addr 8", 64'(acc_q[8]), 64'h110);
    chk("t1 sof w0", 64'(rx_q[0][33]), 64'd1);
    chk("t1 last w7", 64'(rx_q[7][32]), 64'd1);
    chk("t1 last w15", 64'(rx_q[15][32]), 64'd1);
    chk("t1 bursts", 64'(nbursts), 64'd2);
    chk("t1 burst lens", 64'({blen_q[0][7:0], blen_q[1][7:0]}), 64'h0808);
    chk("t1 ack to valid", 64'(first_vld_cyc - first_ack_cyc), 64'd1);
    chk("t1 busy fall", 64'(busy_fall_cyc - last_ack_cyc), 64'd1);

    // Line of 40 split into 16+16+8
    clear_stats();
    pulse(24'h002000, 24'h000000, 11'd40, 11'd1);
    wait_done("t2", 40);
    check_frame("t2", 24'h002000, 24'h000000, 40, 1);
    chk("t2 bursts", 64'(nbursts), 64'd3);
    chk("t2 burst lens", 64'({blen_q[0][7:0], blen_q[1][7:0], blen_q[2][7:0]}), 64'h101008);
    n = 0;
    foreach (rx_q[i]) if (rx_q[i][32]) n++;
    chk("t2 last count", 64'(n), 64'd1);

    // Backpressure: 8 lines of 300 with the sink stopped; fetch stalls at 1012 words
    // (3 lines + 7 bursts of 16; the next 16-word burst does not fit in the last 12)
    clear_stats(); rdy_mode = 0;
    pulse(24'h010000, 24'h000200, 11'd300, 11'd8);
    for (int i = 0; i < 2000; i++) tick();
    chk("t3 stopped at", 64'(n_acc), 64'd1012);
    chk("t3 still busy", 64'(busy), 64'd1);
    chk("t3 nothing out", 64'(rx_q.size()), 64'd0);
    rdy_mode = 1;
    wait_done("t3", 2400);
    check_frame("t3", 24'h010000, 24'h000200, 300, 8);
    chk("t3 room bound", 64'(max_infl <= 1024), 64'd1);

    // Stall and ack jitter, address wrap at 2^24
    clear_stats(); rdy_mode = 2; stall_pct = 40; ack_dmax = 5;
    pulse(24'hFFFFF0, 24'h000020, 11'd20, 11'd4);
    wait_done("t4", 80);
    check_frame("t4", 24'hFFFFF0, 24'h000020, 20, 4);
    chk("t4 stall hold", 64'(stall_bad), 64'd0);
    stall_pct = 0; ack_dmax = 0;

    // Bus error on the 5th ack
    clear_stats(); rdy_mode = 0; err_after = 5;
    pulse(24'h000300, 24'h000040, 11'd16, 11'd2);
    n = 0;
    while (!err_seen && n < 200) begin tick(); n++; end
    chk("t5 err seen", 64'(err_seen), 64'd1);
    chk("t5 cyc dropped", 64'(wb_cyc), 64'd0);
    chk("t5 err flag", 64'(err), 64'd1);
    chk("t5 fifo flushed", 64'(valid), 64'd0);
    stb_cnt = 0;
    for (int i = 0; i < 20; i++) tick();
    chk("t5 no stb after", 64'(stb_cnt), 64'd0);
    chk("t5 err sticky", 64'(err), 64'd1);
    clear_stats(); err_after = 0; rdy_mode = 1;
    pulse(24'h000300, 24'h000040, 11'd8, 11'd1);
    chk("t5 err cleared", 64'(err), 64'd0);
    wait_done("t5", 8);
    check_frame("t5", 24'h000300, 24'h000040, 8, 1);

    // Restart mid-line 3 with the sink stopped
    clear_stats(); rdy_mode = 0;
    pulse(24'h004000, 24'h000040, 11'd16, 11'd5);
    n = 0;
    while (n_acc < 40 && n < 500) begin tick(); n++; end
    chk("t6 reached line 3", 64'(n_acc >= 40), 64'd1);
    clear_stats();
    baseaddr = 24'h005000; stride = 24'h000010; linewords = 11'd6; nlines = 11'd1;
    newframe = 1'b1;
    #1;
    chk("t6 cyc drops", 64'(wb_cyc), 64'd0);
    tick();
    newframe = 1'b0;
    chk("t6 valid flushed", 64'(valid), 64'd0);
    rdy_mode = 1;
    wait_done("t6", 6);
    chk("t6 sof first", 64'(rx_q[0][33]), 64'd1);
    check_frame("t6", 24'h005000, 24'h000010, 6, 1);

    // Degenerate frames
    clear_stats();
    pulse(24'h000000, 24'h000000, 11'd4, 11'd0);
    for (int i = 0; i < 10; i++) tick();
    chk("t7 nlines0 busy", 64'(busy_cnt), 64'd1);
    chk("t7 nlines0 stb", 64'(stb_cnt), 64'd0);
    clear_stats();
    pulse(24'h000000, 24'h000000, 11'd0, 11'd3);
    for (int i = 0; i < 10; i++) tick();
    chk("t7 lw0 busy", 64'(busy_cnt), 64'd1);
    chk("t7 lw0 stb/words", 64'(stb_cnt + rx_q.size()), 64'd0);

    // Reset held low mid-burst
    clear_stats();
    pulse(24'h000800, 24'h000001, 11'd64, 11'd2);
    n = 0;
    while (n_acc < 5 && n < 100) begin tick(); n++; end
    chk("t8 mid burst", 64'(wb_stb), 64'd1);
    reset_n = 1'b0;
    tick();
    chk("t8 rst bus", 64'({wb_cyc, wb_stb, wb_addr}), 64'd0);
    chk("t8 rst stream", 64'({valid, sof, last, busy, err}), 64'd0);
    reset_n = 1'b1;
    tick(); tick();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
